ifu_prefetch: RTL and testbench

- Parametrised successor to the single-PC instruction fetch unit.
- Owns the fetch PC and drives a synchronous instruction memory with 1-cycle read latency.
- Buffers fetched words in a FIFO and hands {pc, instr} to decode over a valid/ready handshake.
- Supports a programmable startup hold-off and PC redirect (branch/jump) with flush of buffered and in-flight fetches.

---
 rtl/ifu_prefetch.sv | 113 +++++++++++
 tb/tb_ifu_prefetch.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_prefetch.sv
// ifu_prefetch: prefetching instruction fetch unit with startup hold-off, redirect/flush and a {pc, instr} output FIFO.
// Ports:
//   clock, reset (async active-low)
//   imem_req/imem_addr/imem_rdata : synchronous instruction memory, 1-cycle read latency
//   redirect_valid/redirect_pc    : one-cycle restart of fetch at a new PC, flushes all buffered work
//   out_valid/out_ready/out_instr/out_pc : decode handshake on the FIFO head
//   fifo_count                    : current FIFO occupancy
// Optional feature macro IFU_MISALIGN_TRAP_EN adds output misalign_err: a misaligned redirect
// target halts fetch until the next aligned redirect. Without it, redirect_pc[1:0] are ignored.
module ifu_prefetch #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] PC_RESET = '0,
  parameter int FIFO_DEPTH = 4,
  parameter int STARTUP_WAIT = 1
) (
  input  logic clock,
  input  logic reset,
  output logic imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic out_valid,
  input  logic out_ready,
  output logic [31:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
`ifdef IFU_MISALIGN_TRAP_EN
  ,
  output logic misalign_err
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int WW = $clog2(STARTUP_WAIT + 2);
  localparam logic [WW-1:0] WAIT_LAST = WW'(STARTUP_WAIT == 0 ? 0 : STARTUP_WAIT - 1);
  localparam logic [AW+1:0] FULL = (AW+2)'(FIFO_DEPTH);
  typedef enum logic {S_WAIT, S_RUN} state_t;
  state_t state, state_nx;
  logic [WW-1:0] wait_cnt;
  logic [XLEN-1:0] fetch_pc, issue_pc, redirect_tgt;
  logic inflight, running, halted, push, pop;
  logic [AW+1:0] credit;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [31:0] fifo_instr [FIFO_DEPTH];
  logic [XLEN-1:0] fifo_pc [FIFO_DEPTH];
  assign redirect_tgt = redirect_pc & ~XLEN'(3);
  assign push = inflight && !redirect_valid;
  assign pop = out_valid && out_ready && !redirect_valid;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_WAIT;
    else state <= state_nx;
  end
  // In-flight requests count against FIFO space so a response always has a slot;
  // a same-cycle pop is not credited, which keeps the check purely registered.
  always_comb begin
    running = state == S_RUN || STARTUP_WAIT == 0;
    state_nx = (state == S_WAIT && (STARTUP_WAIT == 0 || wait_cnt == WAIT_LAST)) ? S_RUN : state;
    credit = {1'b0, count} + (AW+2)'(inflight);
    imem_req = running && !halted && !redirect_valid && credit < FULL;
    imem_addr = fetch_pc;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) wait_cnt <= '0;
    else if (state == S_WAIT) wait_cnt <= wait_cnt + 1'b1;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc <= PC_RESET;
      issue_pc <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= imem_req;
      if (imem_req) issue_pc <= fetch_pc;
      fetch_pc <= redirect_valid ? redirect_tgt : imem_req ? fetch_pc + XLEN'(4) : fetch_pc;
    end
  end
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_instr[wr_ptr] <= imem_rdata;
      fifo_pc[wr_ptr] <= issue_pc;
    end
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (redirect_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end
  // Head fields read as zero when empty so the idle outputs are deterministic.
  assign out_valid = count != '0;
  assign out_instr = out_valid ? fifo_instr[rd_ptr] : '0;
  assign out_pc = out_valid ? fifo_pc[rd_ptr] : '0;
  assign fifo_count = count;
`ifdef IFU_MISALIGN_TRAP_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) misalign_err <= 1'b0;
    else if (redirect_valid) misalign_err <= redirect_pc[1:0] != 2'b00;
  end
  assign halted = misalign_err;
`else
  assign halted = 1'b0;
`endif
endmodule

// File: tb/tb_ifu_prefetch.sv
// tb_ifu_prefetch: directed scoreboard bench for ifu_prefetch.
module tb_ifu_prefetch;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [31:0] out_instr, out_pc;
  logic [2:0] fifo_count;
  logic w_req, w_valid;
  logic [31:0] w_addr, w_instr, w_pc;
  logic [31:0] w_rdata = '0;
  logic [2:0] w_count;
`ifdef IFU_MISALIGN_TRAP_EN
  logic misalign_err, w_err;
`endif
  int checks = 0;
  int failures = 0;
  int pops = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;

  ifu_prefetch u_dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .fifo_count(fifo_count)
`ifdef IFU_MISALIGN_TRAP_EN
    , .misalign_err(misalign_err)
`endif
  );

  ifu_prefetch #(.PC_RESET(32'hFFFF_FFF8), .STARTUP_WAIT(0)) u_wrap (
    .clock(clock), .reset(reset),
    .imem_req(w_req), .imem_addr(w_addr), .imem_rdata(w_rdata),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .out_valid(w_valid), .out_ready(1'b1), .out_instr(w_instr), .out_pc(w_pc),
    .fifo_count(w_count)
`ifdef IFU_MISALIGN_TRAP_EN
    , .misalign_err(w_err)
`endif
  );

  always #5 clock = ~clock;
  always @(posedge clock) if (imem_req) imem_rdata <= ~imem_addr;
  always @(posedge clock) if (w_req) w_rdata <= ~w_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic expect_seq(input logic [31:0] start, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  task automatic drive_point();
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (reset && out_valid && out_ready && !redirect_valid) begin
      pops++;
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL out_unexpected got=%h exp=none", out_pc);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("out_pc", out_pc, e);
        check("out_instr", out_instr, ~e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, nreq, k;
    bit seen;
    // reset state and first-fetch latency
    out_ready = 1'b1;
    expect_seq(32'h0, 64);
    repeat (2) @(negedge clock);
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", out_valid, 0);
    check("rst_instr", out_instr, 32'h0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_count", fifo_count, 0);
    drive_point();
    reset = 1'b1;
    @(negedge clock);
    check("wait_req", imem_req, 0);
    check("w_req0", w_req, 1);
    check("w_addr0", w_addr, 32'hFFFF_FFF8);
    @(negedge clock);
    check("first_req", imem_req, 1);
    check("first_addr", imem_addr, 32'h0);
    check("valid_c2", out_valid, 0);
    @(negedge clock);
    check("second_addr", imem_addr, 32'h4);
    check("valid_c3", out_valid, 0);
    check("w_valid0", w_valid, 1);
    check("w_pc0", w_pc, 32'hFFFF_FFF8);
    @(negedge clock);
    check("valid_c4", out_valid, 1);
    check("w_pc1", w_pc, 32'hFFFF_FFFC);
    @(negedge clock);
    check("w_pc2", w_pc, 32'h0);
    repeat (5) @(negedge clock);
    check("stream_progress", pops >= 6, 1);
    // redirect while a response is in flight
    drive_point();
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    expect_seq(32'h100, 32);
    @(negedge clock);
    check("redir_noreq", imem_req, 0);
    drive_point();
    redirect_valid = 1'b0;
    @(negedge clock);
    check("redir_valid", out_valid, 0);
    check("redir_count", fifo_count, 0);
    check("redir_req", imem_req, 1);
    check("redir_addr", imem_addr, 32'h100);
    p0 = pops;
    repeat (8) @(negedge clock);
    check("redir_progress", pops - p0 >= 5, 1);
    // PC wrap through the top of the address space
    drive_point();
    redirect_valid = 1'b1;
`ifdef IFU_MISALIGN_TRAP_EN
    redirect_pc = 32'hFFFF_FFF8;
`else
    redirect_pc = 32'hFFFF_FFFB;
`endif
    expect_seq(32'hFFFF_FFF8, 32);
    drive_point();
    redirect_valid = 1'b0;
    @(negedge clock);
    check("wrap_addr", imem_addr, 32'hFFFF_FFF8);
    p0 = pops;
    repeat (8) @(negedge clock);
    check("wrap_progress", pops - p0 >= 5, 1);
    // full FIFO stall with out_ready low
    drive_point();
    reset = 1'b0;
    out_ready = 1'b0;
    exp_q.delete();
    drive_point();
    reset = 1'b1;
    nreq = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (imem_req) begin
        check("stall_addr", imem_addr, 32'(4 * nreq));
        nreq++;
      end
    end
    check("stall_nreq", nreq, 4);
    check("stall_count", fifo_count, 4);
    check("stall_req", imem_req, 0);
    check("stall_valid", out_valid, 1);
    check("stall_pc", out_pc, 32'h0);
    @(negedge clock);
    check("stall_hold_pc", out_pc, 32'h0);
    check("stall_hold_instr", out_instr, 32'hFFFF_FFFF);
    drive_point();
    expect_seq(32'h0, 32);
    out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(negedge clock);
      if (imem_req) begin
        seen = 1'b1;
        check("resume_addr", imem_addr, 32'h10);
      end
    end
    check("resume_seen", seen, 1);
    p0 = pops;
    repeat (8) @(negedge clock);
    check("resume_progress", pops - p0 >= 6, 1);
    // asynchronous reset with 3 buffered entries
    drive_point();
    reset = 1'b0;
    out_ready = 1'b0;
    exp_q.delete();
    drive_point();
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      if (fifo_count == 3) seen = 1'b1;
    end
    check("fill3_seen", seen, 1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_count", fifo_count, 0);
    check("arst_req", imem_req, 0);
    check("arst_addr", imem_addr, 32'h0);
    drive_point();
    expect_seq(32'h0, 32);
    out_ready = 1'b1;
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(negedge clock);
      if (imem_req) begin
        seen = 1'b1;
        check("restart_addr", imem_addr, 32'h0);
      end
    end
    check("restart_seen", seen, 1);
    p0 = pops;
    repeat (8) @(negedge clock);
    check("restart_progress", pops - p0 >= 6, 1);
`ifdef IFU_MISALIGN_TRAP_EN
    // misaligned redirect halts fetch until an aligned redirect
    drive_point();
    redirect_valid = 1'b1;
    redirect_pc = 32'h102;
    exp_q.delete();
    drive_point();
    redirect_valid = 1'b0;
    k = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("mis_err", misalign_err, 1);
      check("mis_noreq", imem_req, 0);
      k += int'(out_valid);
    end
    check("mis_novalid", k, 0);
    drive_point();
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    expect_seq(32'h200, 32);
    drive_point();
    redirect_valid = 1'b0;
    @(negedge clock);
    check("mis_clear", misalign_err, 0);
    check("mis_req", imem_req, 1);
    check("mis_addr", imem_addr, 32'h200);
    p0 = pops;
    repeat (8) @(negedge clock);
    check("mis_progress", pops - p0 >= 5, 1);
`endif
    repeat (2) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
